// File: rtl/xlr8_crc16.sv
// xlr8_crc16 -- IO-mapped CRC-16 engine (MSB-first, non-reflected, no output XOR).
// Default build shifts one data bit per clock (8-cycle busy window per byte).
// Define XLR8_CRC16_FAST_EN to fold the whole byte into the accepting edge;
// the register map is the same in both builds.
module xlr8_crc16 #(
  parameter logic [5:0] CTRL_ADDR = 6'h20,
  parameter logic [5:0] DATA_ADDR = 6'h21,
  parameter logic [5:0] CRCL_ADDR = 6'h22,
  parameter logic [5:0] CRCH_ADDR = 6'h23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] adr,
  input  logic       iore,
  input  logic       iowe,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  output logic       io_out_en
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_reg, state_next;
  logic [15:0] crc_reg, crc_next;
  logic [7:0]  data_reg, data_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        poly_sel_reg, poly_sel_next;
  logic        ovr_reg, ovr_next;

  logic        busy;
  logic [15:0] poly;
  logic        hit_ctrl, hit_data, hit_crcl, hit_crch, hit;
  logic        wr_ctrl, wr_data, wr_crcl, wr_crch;

  // One LFSR step: feedback is the outgoing crc MSB xor the incoming data bit.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d,
                                           input logic [15:0] p);
    crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ d) ? p : 16'h0000);
  endfunction

  // Whole byte, MSB first (only used by the single-cycle build).
  function automatic logic [15:0] crc_byte(input logic [15:0] seed, input logic [7:0] d,
                                           input logic [15:0] p);
    logic [15:0] c;
    c = seed;
    for (int i = 7; i >= 0; i--) c = crc_step(c, d[i], p);
    crc_byte = c;
  endfunction

  assign busy = (state_reg == SHIFT);
  assign poly = poly_sel_reg ? 16'h8005 : 16'h1021;

  assign hit_ctrl = (adr == CTRL_ADDR);
  assign hit_data = (adr == DATA_ADDR);
  assign hit_crcl = (adr == CRCL_ADDR);
  assign hit_crch = (adr == CRCH_ADDR);
  assign hit      = hit_ctrl | hit_data | hit_crcl | hit_crch;

  assign wr_ctrl = iowe & hit_ctrl;
  assign wr_data = iowe & hit_data;
  assign wr_crcl = iowe & hit_crcl;
  assign wr_crch = iowe & hit_crch;

  // State register; reset wins over any bus write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      crc_reg      <= 16'hFFFF;
      data_reg     <= 8'h00;
      cnt_reg      <= 3'd0;
      poly_sel_reg <= 1'b0;
      ovr_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      crc_reg      <= crc_next;
      data_reg     <= data_next;
      cnt_reg      <= cnt_next;
      poly_sel_reg <= poly_sel_next;
      ovr_reg      <= ovr_next;
    end
  end

  // Next-state: bit-serial shifting, then bus writes layered on top (init aborts a shift).
  always_comb begin
    state_next    = state_reg;
    crc_next      = crc_reg;
    data_next     = data_reg;
    cnt_next      = cnt_reg;
    poly_sel_next = poly_sel_reg;
    ovr_next      = ovr_reg;

    if (state_reg == SHIFT) begin
      crc_next  = crc_step(crc_reg, data_reg[7], poly);
      data_next = {data_reg[6:0], 1'b0};
      cnt_next  = cnt_reg + 3'd1;
      if (cnt_reg == 3'd7) state_next = IDLE;
    end

    if (wr_ctrl) begin
      if (dbus_in[6]) ovr_next = 1'b0;
      // poly_sel is frozen mid-byte unless the same write also aborts the byte.
      if (!busy || dbus_in[7]) poly_sel_next = dbus_in[0];
      if (dbus_in[7]) begin
        crc_next   = 16'hFFFF;
        state_next = IDLE;
        cnt_next   = 3'd0;
      end
    end

    if (wr_data) begin
      if (busy) begin
        ovr_next = 1'b1;
      end else begin
`ifdef XLR8_CRC16_FAST_EN
        crc_next = crc_byte(crc_reg, dbus_in, poly);
`else
        state_next = SHIFT;
        data_next  = dbus_in;
        cnt_next   = 3'd0;
`endif
      end
    end

    if (wr_crcl) begin
      if (busy) ovr_next = 1'b1;
      else      crc_next[7:0] = dbus_in;
    end

    if (wr_crch) begin
      if (busy) ovr_next = 1'b1;
      else      crc_next[15:8] = dbus_in;
    end
  end

  assign io_out_en = iore & hit;

  // Read mux: zero unless a read hits one of our registers; DATA reads back as zero.
  always_comb begin
    dbus_out = 8'h00;
    if (io_out_en) begin
      if (hit_ctrl)      dbus_out = {busy, ovr_reg, 5'b00000, poly_sel_reg};
      else if (hit_crcl) dbus_out = crc_reg[7:0];
      else if (hit_crch) dbus_out = crc_reg[15:8];
    end
  end

endmodule
